// File: rtl/spi_pkg.sv
// Shared definitions for the 24-bit SPI responder: word/counter widths,
// SPI mode decode helpers and the frame FSM state type.
package spi_pkg;

    localparam int unsigned SPI_WORD_W = 24;
    localparam int unsigned SPI_CNT_W  = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    // Clock polarity: modes 2 and 3 idle high.
    function automatic logic spi_cpol(input int unsigned mode);
        return 1'(mode >> 1);
    endfunction

    // Clock phase: modes 1 and 3 shift on the leading edge.
    function automatic logic spi_cpha(input int unsigned mode);
        return 1'(mode);
    endfunction

endpackage

// File: rtl/spi_slave_24_if.sv
// Word-side handshake and SPI pad signals of spi_slave_24.
// Signal names keep the responder's point of view (i_ = into the responder).
// o_Frame_Err exists only when SPI_SLAVE_FRAME_ERR_EN is defined.
interface spi_slave_24_if;
    import spi_pkg::*;

    logic [SPI_WORD_W-1:0] i_TX_Word;
    logic                  i_TX_DV;
    logic                  o_TX_Ready;
    logic [SPI_WORD_W-1:0] o_RX_Word;
    logic                  o_RX_DV;
    logic                  i_SPI_Clk;
    logic                  i_SPI_CS_n;
    logic                  i_SPI_MOSI;
    logic                  o_SPI_MISO;
    logic                  o_SPI_MISO_En;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic                  o_Frame_Err;
`endif

    modport slave (
        input  i_TX_Word, i_TX_DV, i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI,
        output o_TX_Ready, o_RX_Word, o_RX_DV, o_SPI_MISO, o_SPI_MISO_En
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , output o_Frame_Err
`endif
    );

    modport master (
        output i_TX_Word, i_TX_DV, i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI,
        input  o_TX_Ready, o_RX_Word, o_RX_DV, o_SPI_MISO, o_SPI_MISO_En
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , input o_Frame_Err
`endif
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with edge detection for one asynchronous input.
// Ports: i_Clk, i_Rst_L (async, active-low), i_Async (raw input),
//        o_Sync (synchronized level), o_Rise_c / o_Fall_c (edge strobes
//        from the last two synchronized samples).
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Async,
    output logic o_Sync,
    output logic o_Rise_c,
    output logic o_Fall_c
);

    // pipe[STAGES-1] is the synchronized sample, pipe[STAGES] the one before it.
    logic [STAGES:0] pipe_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) pipe_q <= {(STAGES+1){RST_VAL}};
        else          pipe_q <= {pipe_q[STAGES-1:0], i_Async};
    end

    assign o_Sync   = pipe_q[STAGES-1];
    assign o_Rise_c =  pipe_q[STAGES-1] & ~pipe_q[STAGES];
    assign o_Fall_c = ~pipe_q[STAGES-1] &  pipe_q[STAGES];

endmodule

// File: rtl/spi_slave_24.sv
// 24-bit SPI responder, MSB first, back-to-back words while CS stays low.
// SPI clock, CS and MOSI are oversampled into i_Clk (>= 8x SPI clock).
// Ports: i_Clk, i_Rst_L (async, active-low), bus (spi_slave_24_if.slave):
//   TX word/strobe/ready, RX word/strobe, SPI clock/CS/MOSI/MISO/MISO enable.
// Optional: define SPI_SLAVE_FRAME_ERR_EN to add o_Frame_Err.
module spi_slave_24
    import spi_pkg::*;
#(
    parameter int unsigned SPI_MODE    = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    spi_slave_24_if.slave        bus
);

    localparam logic CPOL = spi_cpol(SPI_MODE);
    localparam logic CPHA = spi_cpha(SPI_MODE);
    localparam logic [SPI_CNT_W-1:0] LAST_BIT = SPI_CNT_W'(SPI_WORD_W - 1);

    logic       sclk_rise_c, sclk_fall_c, sclk_sync_unused;
    logic       cs_sync, cs_rise_c, cs_fall_c;
    logic       mosi_sync;
    logic [1:0] mosi_edge_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Async(bus.i_SPI_Clk),
        .o_Sync(sclk_sync_unused), .o_Rise_c(sclk_rise_c), .o_Fall_c(sclk_fall_c)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Async(bus.i_SPI_CS_n),
        .o_Sync(cs_sync), .o_Rise_c(cs_rise_c), .o_Fall_c(cs_fall_c)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Async(bus.i_SPI_MOSI),
        .o_Sync(mosi_sync), .o_Rise_c(mosi_edge_unused[0]), .o_Fall_c(mosi_edge_unused[1])
    );

    // Leading edge leaves the idle level; CPHA picks which edge samples.
    logic lead_c, trail_c, sample_edge_c, shift_edge_c;
    assign lead_c        = CPOL ? sclk_fall_c : sclk_rise_c;
    assign trail_c       = CPOL ? sclk_rise_c : sclk_fall_c;
    assign sample_edge_c = CPHA ? trail_c : lead_c;
    assign shift_edge_c  = CPHA ? lead_c  : trail_c;

    // CS is only trusted after a real high sample has passed the synchronizer,
    // so a frame already running at reset release is ignored.
    logic [SYNC_STAGES-1:0] flush_q;
    logic                   cs_armed_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            flush_q    <= '0;
            cs_armed_q <= 1'b0;
        end else begin
            flush_q    <= {flush_q[SYNC_STAGES-2:0], 1'b1};
            cs_armed_q <= cs_armed_q | (flush_q[SYNC_STAGES-1] & cs_sync);
        end
    end

    // Frame FSM.
    spi_state_e state_q, state_d;
    logic       start_c, go_idle_c, sample_c, shift_c;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_c   = 1'b0;
        go_idle_c = 1'b0;
        sample_c  = 1'b0;
        shift_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall_c && cs_armed_q) begin
                    state_d = ACTIVE;
                    start_c = 1'b1;
                end
            end
            ACTIVE: begin
                // CS deassertion takes priority over a coincident SPI edge.
                if (cs_rise_c) begin
                    state_d   = IDLE;
                    go_idle_c = 1'b1;
                end else begin
                    sample_c = sample_edge_c;
                    shift_c  = shift_edge_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [SPI_CNT_W-1:0]  bit_cnt_q;
    logic                  wrap_c, consume_c;
    assign wrap_c    = sample_c && (bit_cnt_q == '0);
    assign consume_c = start_c || wrap_c;

    // Datapath: holding register, shifters, outputs.
    logic [SPI_WORD_W-1:0] tx_hold_q, tx_shift_q, rx_word_q;
    logic [SPI_WORD_W-2:0] rx_shift_q;
    logic                  tx_ready_q, rx_done_q, rx_dv_q, miso_q, miso_en_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_hold_q  <= '0;
            tx_ready_q <= 1'b1;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_word_q  <= '0;
            rx_done_q  <= 1'b0;
            rx_dv_q    <= 1'b0;
            bit_cnt_q  <= LAST_BIT;
            miso_q     <= 1'b0;
            miso_en_q  <= 1'b0;
        end else begin
            rx_done_q <= wrap_c;
            rx_dv_q   <= rx_done_q;

            // A write in the consume cycle lands in the holding register.
            if (bus.i_TX_DV) begin
                tx_hold_q  <= bus.i_TX_Word;
                tx_ready_q <= 1'b0;
            end else if (consume_c) begin
                tx_ready_q <= 1'b1;
            end

            if (consume_c) tx_shift_q <= tx_ready_q ? '0 : tx_hold_q;

            if (start_c) begin
                bit_cnt_q <= LAST_BIT;
                miso_en_q <= 1'b1;
                if (!CPHA) miso_q <= tx_ready_q ? 1'b0 : tx_hold_q[SPI_WORD_W-1];
            end

            if (go_idle_c) begin
                bit_cnt_q <= LAST_BIT;
                miso_en_q <= 1'b0;
            end

            if (sample_c) begin
                rx_shift_q <= {rx_shift_q[SPI_WORD_W-3:0], mosi_sync};
                if (bit_cnt_q == '0) begin
                    rx_word_q <= {rx_shift_q, mosi_sync};
                    bit_cnt_q <= LAST_BIT;
                end else begin
                    bit_cnt_q <= bit_cnt_q - SPI_CNT_W'(1);
                end
            end

            // Count already points at the next bit to present.
            if (shift_c) miso_q <= tx_shift_q[bit_cnt_q];
        end
    end

    assign bus.o_TX_Ready    = tx_ready_q;
    assign bus.o_RX_Word     = rx_word_q;
    assign bus.o_RX_DV       = rx_dv_q;
    assign bus.o_SPI_MISO    = miso_q;
    assign bus.o_SPI_MISO_En = miso_en_q;

`ifdef SPI_SLAVE_FRAME_ERR_EN
    // Partial word at CS release, or SPI clock activity while deselected.
    logic frame_err_q;
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) frame_err_q <= 1'b0;
        else          frame_err_q <= (go_idle_c && (bit_cnt_q != LAST_BIT)) ||
                                     (cs_sync && (sclk_rise_c || sclk_fall_c));
    end
    assign bus.o_Frame_Err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_24.sv
// Bench for spi_slave_24: one instance per SPI mode, a bit-level SPI master
// model, and a word-level model of the TX holding register.
module tb_spi_slave_24;
    import spi_pkg::*;

    localparam int HP = 4;  // SPI half period in i_Clk cycles (8x ratio)

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  spi_clk, cs_n, mosi, tx_dv;
    logic [23:0] tx_word [4];
    wire  [3:0]  miso, miso_en, tx_ready, rx_dv;
    wire  [23:0] rx_word [4];
`ifdef SPI_SLAVE_FRAME_ERR_EN
    wire  [3:0]  frame_err;
`endif

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_24_if bus ();
        assign bus.i_TX_Word  = tx_word[g];
        assign bus.i_TX_DV    = tx_dv[g];
        assign bus.i_SPI_Clk  = spi_clk[g];
        assign bus.i_SPI_CS_n = cs_n[g];
        assign bus.i_SPI_MOSI = mosi[g];
        assign miso[g]        = bus.o_SPI_MISO;
        assign miso_en[g]     = bus.o_SPI_MISO_En;
        assign tx_ready[g]    = bus.o_TX_Ready;
        assign rx_dv[g]       = bus.o_RX_DV;
        assign rx_word[g]     = bus.o_RX_Word;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        assign frame_err[g]   = bus.o_Frame_Err;
`endif
        spi_slave_24 #(.SPI_MODE(g), .SYNC_STAGES(2)) dut (
            .i_Clk   (clk),
            .i_Rst_L (rst_n),
            .bus     (bus.slave)
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Received-word monitor.
    logic [23:0] rx_q [$];
    int dv_cnt  [4];
    int err_cnt [4];
    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (rx_dv[g] === 1'b1) begin
                rx_q.push_back(rx_word[g]);
                dv_cnt[g]++;
            end
`ifdef SPI_SLAVE_FRAME_ERR_EN
            if (frame_err[g] === 1'b1) err_cnt[g]++;
`endif
        end
    end

    // Holding-register model: a word waits until the next word start.
    logic [23:0] m_hold;
    bit          m_full;
    logic [23:0] mosi_q [$];

    task automatic take_word(output logic [23:0] w);
        w      = m_full ? m_hold : 24'h0;
        m_full = 1'b0;
    endtask

    task automatic load_tx(input int m, input logic [23:0] w);
        tx_word[m] = w;
        tx_dv[m]   = 1'b1;
        @(negedge clk);
        tx_dv[m]   = 1'b0;
        m_hold     = w;
        m_full     = 1'b1;
    endtask

    // Free-running SPI bits with random MOSI, no checking.
    task automatic clock_bits(input int m, input int n);
        bit cpol, cpha;
        cpol = m[1];
        cpha = m[0];
        for (int i = 0; i < n; i++) begin
            if (!cpha) begin
                mosi[m] = 1'($urandom);
                repeat (HP) @(negedge clk);
                spi_clk[m] = ~cpol;
                repeat (HP) @(negedge clk);
                spi_clk[m] = cpol;
            end else begin
                spi_clk[m] = ~cpol;
                mosi[m]    = 1'($urandom);
                repeat (HP) @(negedge clk);
                spi_clk[m] = cpol;
                repeat (HP) @(negedge clk);
            end
        end
    endtask

    // One CS-low frame of nw words; stop_bits>0 releases CS early.
    task automatic run_frame(input int m, input int nw, input int stop_bits,
                             input bit rel0, input logic [23:0] rel0_val, input bit rel_all);
        bit          cpol, cpha, abort;
        logic [23:0] tx, got, exp_tx;
        logic [23:0] exp_rx [$];
        int          nbits;
        cpol  = m[1];
        cpha  = m[0];
        abort = 1'b0;
        nbits = 0;
        rx_q.delete();
        cs_n[m] = 1'b0;
        take_word(exp_tx);
        repeat (HP) @(negedge clk);
        check_eq($sformatf("miso_en_on m%0d", m), 32'(miso_en[m]), 32'd1);
        check_eq($sformatf("tx_ready_at_start m%0d", m), 32'(tx_ready[m]), 32'(!m_full));
        for (int w = 0; w < nw && !abort; w++) begin
            tx  = (mosi_q.size() > 0) ? mosi_q.pop_front() : 24'($urandom);
            got = 24'h0;
            for (int i = 23; i >= 0; i--) begin
                if (stop_bits != 0 && nbits == stop_bits) begin
                    abort = 1'b1;
                    break;
                end
                if (!cpha) begin
                    mosi[m] = tx[i];
                    repeat (HP) @(negedge clk);
                    spi_clk[m] = ~cpol;
                    got[i] = miso[m];
                    repeat (HP) @(negedge clk);
                    spi_clk[m] = cpol;
                end else begin
                    spi_clk[m] = ~cpol;
                    mosi[m]    = tx[i];
                    repeat (HP) @(negedge clk);
                    spi_clk[m] = cpol;
                    got[i] = miso[m];
                    repeat (HP) @(negedge clk);
                end
                nbits++;
                if (i == 12 && ((rel0 && w == 0) || rel_all))
                    load_tx(m, rel_all ? 24'($urandom) : rel0_val);
            end
            if (!abort) begin
                check_eq($sformatf("miso_word m%0d w%0d", m, w), 32'(got), 32'(exp_tx));
                exp_rx.push_back(tx);
                take_word(exp_tx);
            end
        end
        repeat (HP) @(negedge clk);
        cs_n[m] = 1'b1;
        repeat (4 * HP) @(negedge clk);
        check_eq($sformatf("miso_en_off m%0d", m), 32'(miso_en[m]), 32'd0);
        check_eq($sformatf("rx_count m%0d", m), 32'(rx_q.size()), 32'(exp_rx.size()));
        for (int k = 0; k < exp_rx.size() && k < rx_q.size(); k++)
            check_eq($sformatf("rx_word m%0d w%0d", m, k), 32'(rx_q[k]), 32'(exp_rx[k]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int dv_before, err_before;
        spi_clk = 4'b1100;
        cs_n    = 4'hF;
        mosi    = 4'h0;
        tx_dv   = 4'h0;
        for (int g = 0; g < 4; g++) tx_word[g] = 24'h0;
        m_full  = 1'b0;
        m_hold  = 24'h0;
        repeat (4) @(negedge clk);
        check_eq("rst tx_ready", 32'(tx_ready[0]), 32'd1);
        check_eq("rst rx_dv",    32'(rx_dv[0]),    32'd0);
        check_eq("rst rx_word",  32'(rx_word[0]),  32'd0);
        check_eq("rst miso",     32'(miso[0]),     32'd0);
        check_eq("rst miso_en",  32'(miso_en[0]),  32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // Mode 0 single word.
        load_tx(0, 24'hA5C3F0);
        check_eq("tx_ready after load", 32'(tx_ready[0]), 32'd0);
        mosi_q.push_back(24'h123456);
        run_frame(0, 1, 0, 1'b0, 24'h0, 1'b0);
        check_eq("tx_ready after frame", 32'(tx_ready[0]), 32'd1);

        // Mode 3 back-to-back words with mid-word reload.
        load_tx(3, 24'h111111);
        mosi_q.push_back(24'hFFFFFF);
        mosi_q.push_back(24'h000001);
        run_frame(3, 2, 0, 1'b1, 24'h222222, 1'b0);

        // Empty holding register.
        run_frame(0, 1, 0, 1'b0, 24'h0, 1'b0);

        // CS released after 10 bits, then a clean frame.
        err_before = err_cnt[0];
        load_tx(0, 24'($urandom));
        run_frame(0, 1, 10, 1'b0, 24'h0, 1'b0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check_eq("frame_err pulses", 32'(err_cnt[0] - err_before), 32'd1);
`endif
        load_tx(0, 24'($urandom));
        run_frame(0, 1, 0, 1'b0, 24'h0, 1'b0);

        // Reset at bit 12 of a mode 1 frame.
        load_tx(1, 24'($urandom));
        cs_n[1] = 1'b0;
        repeat (HP) @(negedge clk);
        clock_bits(1, 12);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst tx_ready", 32'(tx_ready[1]), 32'd1);
        check_eq("midrst rx_dv",    32'(rx_dv[1]),    32'd0);
        check_eq("midrst rx_word",  32'(rx_word[1]),  32'd0);
        check_eq("midrst miso",     32'(miso[1]),     32'd0);
        check_eq("midrst miso_en",  32'(miso_en[1]),  32'd0);
        m_full = 1'b0;
        rst_n  = 1'b1;
        dv_before = dv_cnt[1];
        clock_bits(1, 12);
        repeat (HP) @(negedge clk);
        check_eq("ignored frame miso_en", 32'(miso_en[1]), 32'd0);
        cs_n[1] = 1'b1;
        repeat (4 * HP) @(negedge clk);
        check_eq("ignored frame rx_dv", 32'(dv_cnt[1] - dv_before), 32'd0);
        load_tx(1, 24'($urandom));
        mosi_q.push_back(24'hDEADBE);
        run_frame(1, 1, 0, 1'b0, 24'h0, 1'b0);

        // Random sweep, 100 words per mode.
        for (int m = 0; m < 4; m++) begin
            for (int f = 0; f < 4; f++) begin
                load_tx(m, 24'($urandom));
                run_frame(m, 25, 0, 1'b0, 24'h0, 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_24.md
Name: spi_slave_24

Overview:
- SPI responder for the far end of our 24-bit SPI master link: the IRS-side block that receives 24-bit command words on MOSI and returns 24-bit status words on MISO.
- Fully synchronous to i_Clk. SPI clock and chip-select are oversampled through synchronizers, never used as clocks.
- Matches the master's framing: MSB first, 24 bits per word, multi-word back-to-back while CS is held low.

Parameters:
- SPI_MODE, 0: SPI mode 0-3. CPOL = mode 2/3; CPHA = mode 1/3.
- SYNC_STAGES, 2: synchronizer depth for i_SPI_Clk, i_SPI_CS_n and i_SPI_MOSI (valid values 2 or 3).

Ports:
- i_Clk, input, 1: system clock. Must be >= 8x the SPI clock frequency.
- i_Rst_L, input, 1: asynchronous, active-low reset.
- i_TX_Word, input, 24: next word to return on MISO.
- i_TX_DV, input, 1: one-cycle pulse that qualifies i_TX_Word.
- o_TX_Ready, output, 1: high when the TX holding register is empty.
- o_RX_Word, output, 24: last complete received word.
- o_RX_DV, output, 1: one-cycle pulse; o_RX_Word is valid during this cycle.
- i_SPI_Clk, input, 1: SPI clock from the master.
- i_SPI_CS_n, input, 1: chip select, active low.
- i_SPI_MOSI, input, 1: serial data in.
- o_SPI_MISO, output, 1: serial data out.
- o_SPI_MISO_En, output, 1: MISO output enable for the pad tristate; high only while selected.

Behaviour:
- Reset values:
  - o_TX_Ready = 1
  - o_RX_DV = 0
  - o_RX_Word = 0
  - o_SPI_MISO = 0
  - o_SPI_MISO_En = 0
  - TX holding register = 0
  - bit count = 23
  - FSM = IDLE
  - synchronizer flops: SPI_Clk flops = CPOL; CS flops = 1
- Edge detection: compare the last two synchronized SPI_Clk samples.
  - Leading edge = transition away from CPOL.
  - Trailing edge = transition back to CPOL.
- Sample/shift rule:
  - CPHA=0: sample MOSI on leading edge, shift MISO on trailing edge.
  - CPHA=1: shift MISO on leading edge, sample MOSI on trailing edge.
- TX holding register:
  - i_TX_DV loads it and clears o_TX_Ready.
  - It is consumed (copied to the TX shift register, o_TX_Ready set to 1) at each word start.
  - i_TX_DV while o_TX_Ready=0 overwrites the held word (last write wins).
  - If the register is empty at word start, the shifter loads 24'h000000.
- FSM states:
  - IDLE:
    - Synchronized CS falling edge -> consume holding register.
    - o_SPI_MISO_En=1. For CPHA=0, drive bit 23 immediately.
    - Go to ACTIVE with bit count 23.
  - ACTIVE:
    - On each sample edge: o_RX shifter[count] <= MOSI; count decrements.
    - At count 0 after sampling:
      - o_RX_Word <= full word; o_RX_DV pulses the next cycle.
      - Count wraps to 23; holding register is consumed for the next word.
      - For CPHA=0, bit 23 of the new word is driven on the following shift edge. No state change; multi-word transfers continue.
    - On each shift edge: drive the next bit, MSB first.
      - CPHA=1: the first leading edge drives bit 23.
      - The shift edge coinciding with a wrap drives bit 23 of the new word.
    - CS rising (synchronized) -> IDLE: o_SPI_MISO_En=0, partial word discarded, no o_RX_DV.
- Latency: o_RX_DV asserts SYNC_STAGES+2 i_Clk cycles after the raw SPI edge carrying bit 0.
- Simultaneous events:
  - i_TX_DV in the same cycle as a word-start consume: the new word goes to the holding register (not the shifter) and o_TX_Ready stays 0.
  - CS rising in the same cycle as a sample edge: CS wins.
- Reset mid-frame: all state returns to reset values immediately. A frame in progress at reset release is ignored until CS is seen high and then low again (FSM only leaves IDLE on a CS falling edge).

Optional Feature:
- Macro: SPI_SLAVE_FRAME_ERR_EN.
- Defined:
  - Adds output o_Frame_Err (1 bit, reset 0).
  - Pulses for one cycle when CS deasserts with bit count != 23 (partial word).
  - Also pulses when an SPI edge is detected while CS is high.
- Undefined: the port is absent; partial words are silently discarded.

Decomposition:
- Shared package spi_pkg:
  - SPI_WORD_W = 24
  - CPOL/CPHA decode functions for SPI_MODE
  - FSM state typedef {IDLE, ACTIVE}
- Sub-module spi_sync_edge: SYNC_STAGES-deep synchronizer plus rise/fall detection, one instance per input (SPI_Clk, CS_n, MOSI). All three inputs use the same depth so data stays aligned with its clock edge.

Test Plan:
- Mode 0, i_Clk = 8x SPI clock:
  - Load i_TX_Word=24'hA5C3F0, master sends 24'h123456.
  - Expect o_RX_DV once with o_RX_Word=24'h123456; master captures 24'hA5C3F0; o_TX_Ready returns to 1 at CS fall.
- Mode 3, two back-to-back words with CS held low:
  - Master sends 24'hFFFFFF then 24'h000001; slave holds 24'h111111, reloaded with 24'h222222 mid-first-word.
  - Expect two o_RX_DV pulses in order; MISO returns 24'h111111 then 24'h222222.
- Empty holding register: no i_TX_DV before the frame -> master reads 24'h000000; RX still correct.
- CS rises after 10 bits:
  - Expect no o_RX_DV and o_SPI_MISO_En=0.
  - With SPI_SLAVE_FRAME_ERR_EN defined, expect one o_Frame_Err pulse.
  - The next full frame receives correctly.
- Assert i_Rst_L low at bit 12, release, then run a full mode 1 frame 24'hDEADBE -> all outputs at reset values during reset; the following frame received correctly.
- Modes 0-3 sweep with random data, 100 words each -> bit-exact RX/TX loopback against the master model.
